// File: rtl/alu_unit_if.sv
// Operand/result bundle between the core datapath and the ALU.
// The master drives operands and fn; the slave returns results.
interface alu_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [3:0]       fn;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;

    modport master (
        output x, y, fn,
        input  out, zero, out_q, zero_q
    );

    modport slave (
        input  x, y, fn,
        output out, zero, out_q, zero_q
    );
endinterface

// File: rtl/alu_unit.sv
// RV32I integer ALU: combinational result/zero plus a registered copy.
// Reserved fn codes yield zero so branch logic never sees X.
module alu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_unit_if.slave  bus
);
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   res_q;
    logic               zero_d;
    logic               zero_q;

    always_comb begin
        shamt = bus.y[SHAMT_W-1:0];
        res_d = '0;
        case (bus.fn)
            4'h0: res_d = bus.x + bus.y;
            4'h8: res_d = bus.x - bus.y;
            4'h1: res_d = bus.x << shamt;
            4'h2: res_d = {{(WIDTH-1){1'b0}},
                           $signed(bus.x) < $signed(bus.y)};
            4'h3: res_d = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
            4'h4: res_d = bus.x ^ bus.y;
            4'h5: res_d = bus.x >> shamt;
            4'hD: res_d = $unsigned($signed(bus.x) >>> shamt);
            4'h6: res_d = bus.x | bus.y;
            4'h7: res_d = bus.x & bus.y;
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out    = res_d;
    assign bus.zero   = zero_d;
    assign bus.out_q  = res_q;
    assign bus.zero_q = zero_q;
endmodule

// File: tb/tb_alu_unit.sv
// Randomized and directed bench for alu_unit against an arithmetic model.
// Also exercises the registered copy and asynchronous reset.
module tb_alu_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_unit_if #(.WIDTH(32)) bus ();

    alu_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  f);
        int unsigned s;
        int          sa;
        int          sb;
        s  = b % 32;
        sa = a;
        sb = b;
        case (f)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << s;
            4'h2: return (sa < sb) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> s;
            4'hD: return a[31] ? ~((~a) >> s) : (a >> s);
            4'h6: return a | b;
            4'h7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive at negedge, check comb path, then the registered copy.
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] f);
        logic [31:0] e;
        @(negedge clk);
        bus.x  = a;
        bus.y  = b;
        bus.fn = f;
        e = ref_alu(a, b, f);
        #1;
        check($sformatf("out fn=%h", f), bus.out, e);
        check($sformatf("zero fn=%h", f), {31'd0, bus.zero},
              {31'd0, e == 32'd0});
        @(posedge clk);
        #1;
        check("out_q", bus.out_q, e);
        check("zero_q", {31'd0, bus.zero_q}, {31'd0, e == 32'd0});
    endtask

    task automatic dir(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f, input logic [31:0] e,
                       input string tag);
        run_vec(a, b, f);
        check(tag, bus.out, e);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        bus.x  = 32'd2;
        bus.y  = 32'd3;
        bus.fn = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        check("rst out_q", bus.out_q, 32'd0);
        check("rst zero_q", {31'd0, bus.zero_q}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst hold out_q", bus.out_q, 32'd0);
        check("rst comb out", bus.out, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first cap", bus.out_q, 32'd5);

        dir(32'hFFFFFFFF, 32'd1, 4'h0, 32'd0, "add wrap");
        dir(32'd0, 32'd1, 4'h8, 32'hFFFFFFFF, "sub wrap");
        dir(32'hFFFFFFFF, 32'd1, 4'h2, 32'd1, "slt");
        dir(32'hFFFFFFFF, 32'd1, 4'h3, 32'd0, "sltu");
        dir(32'd5, 32'd5, 4'h8, 32'd0, "beq");
        dir(32'h80000000, 32'h24, 4'h5, 32'h08000000, "srl");
        dir(32'h80000000, 32'h24, 4'hD, 32'hF8000000, "sra");
        dir(32'd1, 32'd31, 4'h1, 32'h80000000, "sll31");
        dir(32'h8765_4321, 32'h20, 4'h1, 32'h8765_4321, "sll0");
        dir(32'h8765_4321, 32'h40, 4'h5, 32'h8765_4321, "srl0");
        dir(32'h8765_4321, 32'h0, 4'hD, 32'h8765_4321, "sra0");
        dir(32'hF0F0F0F0, 32'h0FF00FF0, 4'h4, 32'hFF00FF00, "xor");
        dir(32'hF0F0F0F0, 32'h0FF00FF0, 4'h6, 32'hFFF0FFF0, "or");
        dir(32'hF0F0F0F0, 32'h0FF00FF0, 4'h7, 32'h00F000F0, "and");
        dir(32'hDEADBEEF, 32'h12345678, 4'hB, 32'd0, "rsvd");

        for (int f = 0; f < 16; f++) begin
            run_vec(32'hDEADBEEF, 32'h12345677, f[3:0]);
        end

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom_range(0, 40);
                default: ;
            endcase
            run_vec(a, b, 4'($urandom_range(0, 15)));
        end

        // Registered path holds across a mid-cycle input change.
        run_vec(32'd2, 32'd3, 4'h0);
        @(negedge clk);
        bus.x  = 32'd7;
        bus.y  = 32'd1;
        bus.fn = 4'h8;
        #1;
        check("hold out_q", bus.out_q, 32'd5);
        check("new out", bus.out, 32'd6);
        @(posedge clk);
        #1;
        check("next out_q", bus.out_q, 32'd6);

        // Async reset between edges.
        run_vec(32'd2, 32'd3, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_q", bus.out_q, 32'd0);
        check("async zero_q", {31'd0, bus.zero_q}, 32'd0);
        check("async out", bus.out, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel hold", bus.out_q, 32'd0);
        @(posedge clk);
        #1;
        check("rel cap", bus.out_q, 32'd5);
        check("rel zero_q", {31'd0, bus.zero_q}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the multi-cycle RISC-V (RV32I) core.
- Executes the R/I-type arithmetic, logic, shift and compare operations. The core also uses it for load/store address addition and branch comparisons.
- Primary result and zero flag are combinational, so the core can use them in the same state they are requested.
- A registered copy of both is provided for pipelined or debug consumers.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; registered outputs update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears registered outputs only.
- x  input  WIDTH  operand 1 (rs1 value).
- y  input  WIDTH  operand 2 (rs2 value or sign-extended immediate).
- fn  input  4  operation select, {alt, funct3}.
- out  output  WIDTH  combinational result.
- zero  output  1  combinational, 1 when out == 0.
- out_q  output  WIDTH  out registered on clk.
- zero_q  output  1  zero registered on clk.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- The combinational path has no clock dependency: out and zero settle within the same cycle for any x, y, fn.
- fn decode (fn[3] = alt bit, fn[2:0] = funct3):
  - 0x0 ADD: x + y, modulo 2^WIDTH, carry discarded.
  - 0x8 SUB: x - y, modulo 2^WIDTH.
  - 0x1 SLL: x << y[SHAMT_W-1:0]; upper bits of y ignored.
  - 0x2 SLT: 1 if signed(x) < signed(y), else 0; result zero-extended.
  - 0x3 SLTU: 1 if unsigned x < unsigned y, else 0.
  - 0x4 XOR: x ^ y.
  - 0x5 SRL: logical right shift of x by y[SHAMT_W-1:0].
  - 0xD SRA: arithmetic right shift of x by y[SHAMT_W-1:0]; sign bit replicated.
  - 0x6 OR: x | y.
  - 0x7 AND: x & y.
  - 0x9, 0xA, 0xB, 0xC, 0xE, 0xF: reserved; out = 0, so zero = 1. These must be free of X propagation.
- zero = (out == 0) for every fn. Branch usage: BEQ/BNE use fn=0x8 and test zero; BLT/BGE use fn=0x2 and test out[0].
- Shift amount of 0 returns x unchanged for SLL, SRL and SRA.
- Registered stage:
  - On each rising clk edge with rst_n high: out_q <= out, zero_q <= zero.
  - Latency is exactly 1 cycle; there is no enable and no handshake.
- Reset:
  - rst_n low forces out_q = 0 and zero_q = 0 immediately, without waiting for clk.
  - Both are held there while rst_n is low.
  - The first capture after reset is at the first rising edge with rst_n high.
  - Deassertion near a clock edge is treated as a normal async reset release; no extra synchronisation is done inside the block.
  - Combinational out/zero are unaffected by reset.
- No internal state other than out_q and zero_q.

Test Plan:
- ADD/SUB wrap: x=0xFFFFFFFF, y=1, fn=0x0 -> out=0, zero=1. fn=0x8, x=0, y=1 -> out=0xFFFFFFFF, zero=0.
- Compares:
  - x=0xFFFFFFFF, y=1, fn=0x2 -> out=1.
  - Same operands, fn=0x3 -> out=0.
  - x=5, y=5, fn=0x8 -> zero=1.
- Shifts:
  - x=0x80000000, y=0x24 (shamt 4), fn=0x5 -> out=0x08000000.
  - fn=0xD -> out=0xF8000000.
  - x=1, y=31, fn=0x1 -> out=0x80000000.
  - shamt 0 for each shift -> out=x.
- Logic:
  - x=0xF0F0F0F0, y=0x0FF00FF0: fn=0x4 -> 0xFF00FF00; fn=0x6 -> 0xFFF0FFF0; fn=0x7 -> 0x00F000F0.
  - Reserved fn=0xB -> out=0, zero=1.
- Registered path:
  - Apply x=2, y=3, fn=0 -> out=5 combinationally; out_q=5, zero_q=0 after the next rising edge.
  - Change inputs mid-cycle -> out_q holds until the following edge.
- Async reset: with out_q=5, drop rst_n between clock edges -> out_q=0 and zero_q=0 immediately while out still shows 5. Release rst_n -> capture resumes on the next edge.
